instr_fetch: RTL and testbench

Instruction fetch stage of the RISC-V core, sitting directly upstream of the word-addressed, combinational-read instruction memory. It owns the program counter, presents a word index to the memory, and registers each returned instruction with its PC into the IF/ID output register under a valid/ready handshake. It handles decode back-pressure, branch/jump redirects, program-load freezes and illegal fetch addresses.

---
 rtl/instr_fetch_if.sv | 22 ++
 rtl/instr_fetch.sv | 78 +++++++
 tb/tb_instr_fetch.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch-stage bus bundling the imem port, execute redirect, loader control and IF/ID handshake
interface instr_fetch_if;
  logic [31:0] imem_adr;
  logic [31:0] imem_out;
  logic        prog_load;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fault;
  logic [31:0] fetch_count;
  modport master (
    output imem_adr, if_valid, if_instr, if_pc, fault, fetch_count,
    input  imem_out, prog_load, redirect, redirect_pc, id_ready
  );
  modport slave (
    input  imem_adr, if_valid, if_instr, if_pc, fault, fetch_count,
    output imem_out, prog_load, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: RISC-V fetch stage; ports clk, rst, bus (master: imem_adr out, imem_out in, prog_load/redirect/redirect_pc/id_ready in, if_valid/if_instr/if_pc/fault/fetch_count out)
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_SIZE = 1024
) (
  input logic            clk,
  input logic            rst,
  instr_fetch_if.master  bus
);
  typedef enum logic [1:0] {RUN, LOADING, FAULT} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, ipc_q, ipc_d, cnt_q, cnt_d;
  logic valid_q, valid_d, fault_q, fault_d;
  logic in_range, xfer;
  assign in_range = pc_q[31:2] < 30'(MEM_SIZE);
  // A handshake counts even on the cycle it is squashed by redirect or load start.
  assign xfer = valid_q & bus.id_ready & (state_q != LOADING);
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    ipc_d = ipc_q;
    valid_d = valid_q;
    fault_d = fault_q;
    cnt_d = cnt_q + 32'(xfer);
    if (bus.prog_load) begin
      state_d = LOADING;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (state_q == LOADING) begin
      state_d = RUN;
      pc_d = RESET_PC;
    end else if (state_q == RUN) begin
      if (bus.redirect) begin
        pc_d = bus.redirect_pc;
        valid_d = 1'b0;
        state_d = (bus.redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
        fault_d = bus.redirect_pc[1:0] != 2'b00;
      end else if (!valid_q || bus.id_ready) begin
        if (in_range) begin
          instr_d = bus.imem_out;
          ipc_d = pc_q;
          valid_d = 1'b1;
          pc_d = pc_q + 32'd4;
        end else begin
          state_d = FAULT;
          fault_d = 1'b1;
          valid_d = 1'b0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      instr_q <= '0;
      ipc_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      ipc_q <= ipc_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.imem_adr = {2'b00, pc_q[31:2]};
  assign bus.if_valid = valid_q;
  assign bus.if_instr = instr_q;
  assign bus.if_pc = ipc_q;
  assign bus.fault = fault_q;
  assign bus.fetch_count = cnt_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch with a full-size and a 4-word instance
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst, prog_load, redirect, id_ready;
  logic [31:0] redirect_pc;
  logic [31:0] mem [1024];
  int errs = 0;
  int checks = 0;
  instr_fetch_if ifa();
  instr_fetch_if ifb();
  instr_fetch #(.MEM_SIZE(1024)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  instr_fetch #(.MEM_SIZE(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  always #5 clk = ~clk;
  assign ifa.imem_out = mem[ifa.imem_adr[9:0]];
  assign ifb.imem_out = mem[ifb.imem_adr[9:0]];
  assign ifa.prog_load = prog_load;
  assign ifb.prog_load = prog_load;
  assign ifa.redirect = redirect;
  assign ifb.redirect = redirect;
  assign ifa.redirect_pc = redirect_pc;
  assign ifb.redirect_pc = redirect_pc;
  assign ifa.id_ready = id_ready;
  assign ifb.id_ready = id_ready;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic exp_a(input string tag, input logic full, input logic v, input logic [31:0] pc,
                       input logic [31:0] ins, input logic [31:0] cnt, input logic f, input logic [31:0] adr);
    chk({tag, ".valid"}, 32'(ifa.if_valid), 32'(v));
    chk({tag, ".count"}, ifa.fetch_count, cnt);
    chk({tag, ".fault"}, 32'(ifa.fault), 32'(f));
    chk({tag, ".adr"}, ifa.imem_adr, adr);
    if (full) begin
      chk({tag, ".pc"}, ifa.if_pc, pc);
      chk({tag, ".instr"}, ifa.if_instr, ins);
    end
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h13 + 32'(i) * 32'h80;
    rst = 1'b1;
    prog_load = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b1;
    tick();
    tick();
    exp_a("reset", 1'b1, 1'b0, 32'h0, 32'h0, 32'd0, 1'b0, 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_a("seq", 1'b1, 1'b1, 32'(k - 1) * 4, 32'h13 + 32'(k - 1) * 32'h80, 32'(k - 1), 1'b0, 32'(k));
    end
    rst = 1'b1;
    tick();
    exp_a("reset_mid", 1'b1, 1'b0, 32'h0, 32'h0, 32'd0, 1'b0, 32'h0);
    rst = 1'b0;
    tick();
    exp_a("r2_e1", 1'b1, 1'b1, 32'h0, 32'h13, 32'd0, 1'b0, 32'h1);
    tick();
    exp_a("r2_e2", 1'b1, 1'b1, 32'h4, 32'h93, 32'd1, 1'b0, 32'h2);
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_a("stall", 1'b1, 1'b1, 32'h4, 32'h93, 32'd1, 1'b0, 32'h2);
    end
    id_ready = 1'b1;
    tick();
    exp_a("release", 1'b1, 1'b1, 32'h8, 32'h113, 32'd2, 1'b0, 32'h3);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    tick();
    exp_a("redir_bubble", 1'b0, 1'b0, 32'h0, 32'h0, 32'd3, 1'b0, 32'h10);
    redirect = 1'b0;
    tick();
    exp_a("redir_tgt", 1'b1, 1'b1, 32'h40, 32'h813, 32'd3, 1'b0, 32'h11);
    tick();
    exp_a("redir_next", 1'b1, 1'b1, 32'h44, 32'h893, 32'd4, 1'b0, 32'h12);
    id_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h80;
    tick();
    exp_a("redir_stall", 1'b0, 1'b0, 32'h0, 32'h0, 32'd4, 1'b0, 32'h20);
    redirect = 1'b0;
    tick();
    exp_a("redir_stall_tgt", 1'b1, 1'b1, 32'h80, 32'h1013, 32'd4, 1'b0, 32'h21);
    tick();
    exp_a("redir_stall_hold", 1'b1, 1'b1, 32'h80, 32'h1013, 32'd4, 1'b0, 32'h21);
    id_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h42;
    tick();
    exp_a("misalign", 1'b0, 1'b0, 32'h0, 32'h0, 32'd5, 1'b1, 32'h10);
    redirect = 1'b0;
    tick();
    exp_a("fault_hold", 1'b0, 1'b0, 32'h0, 32'h0, 32'd5, 1'b1, 32'h10);
    redirect = 1'b1;
    redirect_pc = 32'h0;
    tick();
    exp_a("fault_ign_redir", 1'b0, 1'b0, 32'h0, 32'h0, 32'd5, 1'b1, 32'h10);
    redirect = 1'b0;
    prog_load = 1'b1;
    tick();
    exp_a("load_clr", 1'b0, 1'b0, 32'h0, 32'h0, 32'd5, 1'b0, 32'h10);
    prog_load = 1'b0;
    tick();
    exp_a("load_exit", 1'b0, 1'b0, 32'h0, 32'h0, 32'd5, 1'b0, 32'h0);
    tick();
    exp_a("load_first", 1'b1, 1'b1, 32'h0, 32'h13, 32'd5, 1'b0, 32'h1);
    tick();
    exp_a("load_second", 1'b1, 1'b1, 32'h4, 32'h93, 32'd6, 1'b0, 32'h2);
    prog_load = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    exp_a("pl_redir", 1'b0, 1'b0, 32'h0, 32'h0, 32'd7, 1'b0, 32'h2);
    redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_a("pl_hold", 1'b0, 1'b0, 32'h0, 32'h0, 32'd7, 1'b0, 32'h2);
    end
    prog_load = 1'b0;
    tick();
    exp_a("pl_fall", 1'b0, 1'b0, 32'h0, 32'h0, 32'd7, 1'b0, 32'h0);
    tick();
    exp_a("pl_first", 1'b1, 1'b1, 32'h0, 32'h13, 32'd7, 1'b0, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("small.valid", 32'(ifb.if_valid), 32'd1);
      chk("small.pc", ifb.if_pc, 32'(k - 1) * 4);
      chk("small.instr", ifb.if_instr, 32'h13 + 32'(k - 1) * 32'h80);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("small_oor.valid", 32'(ifb.if_valid), 32'd0);
      chk("small_oor.fault", 32'(ifb.fault), 32'd1);
      chk("small_oor.count", ifb.fetch_count, 32'd4);
      chk("small_oor.adr", ifb.imem_adr, 32'd4);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
